f779_seq: RTL and testbench

- Command-driven sequencer for one 74F779 8-bit up/down counter with shared 3-state I/O.
- Accepts LOAD / COUNT-UP / COUNT-DOWN / READ commands over a valid/ready interface and drives the device's S0, S1, ~OE and ~CET pins.
- Owns the shared 8-bit I/O bus and enforces bus turnaround, so the controller and the device never drive the bus at the same time.
- Sits between the test/control logic and the device; the device is clocked by the same CP.

---
 rtl/f779_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_f779_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/f779_seq.sv
// Command sequencer for a 74F779 up/down counter sharing a 3-state I/O bus.
// Optional F779_SEQ_STOP_ON_TC_EN: end a COUNT right after the first ~TC low.
module f779_seq #(
    parameter int TURN_CYCLES = 1
) (
    input  logic       cp_i,
    input  logic       mr_n_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_op_i,
    input  logic [7:0] cmd_data_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [7:0] rsp_data_o,
    output logic       rsp_tc_o,
    output logic       s0_o,
    output logic       s1_o,
    output logic       oe_n_o,
    output logic       cet_n_o,
    input  logic       tc_n_i,
    output logic [7:0] bus_o,
    output logic       bus_oe_o,
    input  logic [7:0] bus_i
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD_WAIT = 3'd1;
    localparam logic [2:0] LOAD      = 3'd2;
    localparam logic [2:0] COUNT     = 3'd3;
    localparam logic [2:0] OE_WAIT   = 3'd4;
    localparam logic [2:0] READ      = 3'd5;
    localparam logic [2:0] RESP      = 3'd6;

    localparam logic [1:0] M_LOAD = 2'b00;
    localparam logic [1:0] M_DN   = 2'b01;
    localparam logic [1:0] M_UP   = 2'b10;
    localparam logic [1:0] M_HOLD = 2'b11;

    localparam logic [2:0] TURN = 3'(TURN_CYCLES);
    localparam logic [2:0] RD_LAST = 3'(TURN_CYCLES - 1);

    logic [2:0] state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic       oe_n_q, oe_n_d;
    logic       cet_n_q, cet_n_d;
    logic       bus_oe_q, bus_oe_d;
    logic [7:0] bus_q, bus_d;
    logic       rdy_q, rdy_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_tc_q, rsp_tc_d;
    logic       tc_q, tc_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] n_q, n_d;
    logic [7:0] data_q, data_d;
    logic [2:0] rd_q, rd_d;
    logic [2:0] gap_q, gap_d;
    logic [7:0] steps;
    logic       tc_hit;
    logic       done;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        oe_n_d      = oe_n_q;
        cet_n_d     = cet_n_q;
        bus_oe_d    = bus_oe_q;
        bus_d       = bus_q;
        rdy_d       = rdy_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tc_d    = rsp_tc_q;
        tc_d        = tc_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        data_d      = data_q;
        rd_d        = rd_q;
        // Cycles since either side last released the bus, saturating.
        gap_d       = (gap_q == 3'd7) ? gap_q : gap_q + 3'd1;
        steps       = cnt_q + 8'd1;
        tc_hit      = !tc_n_i;
        done        = (steps == n_q);
`ifdef F779_SEQ_STOP_ON_TC_EN
        done        = done || tc_hit;
`endif
        case (state_q)
            IDLE: begin
                rdy_d = 1'b1;
                if (cmd_valid_i && rdy_q) begin
                    rdy_d  = 1'b0;
                    data_d = cmd_data_i;
                    case (cmd_op_i)
                        2'b00: state_d = LOAD_WAIT;
                        2'b11: state_d = OE_WAIT;
                        default: begin
                            if (cmd_data_i == 8'd0) begin
                                state_d     = RESP;
                                rsp_valid_d = 1'b1;
                                rsp_data_d  = 8'd0;
                                rsp_tc_d    = 1'b0;
                            end else begin
                                state_d = COUNT;
                                mode_d  = (cmd_op_i == 2'b01) ? M_UP : M_DN;
                                cet_n_d = 1'b0;
                                cnt_d   = 8'd0;
                                tc_d    = 1'b0;
                                n_d     = cmd_data_i;
                            end
                        end
                    endcase
                end
            end
            LOAD_WAIT: begin
                if (gap_q >= TURN) begin
                    bus_oe_d = 1'b1;
                    bus_d    = data_q;
                    mode_d   = M_LOAD;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                bus_oe_d    = 1'b0;
                bus_d       = 8'd0;
                mode_d      = M_HOLD;
                gap_d       = 3'd0;
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = 8'd0;
                rsp_tc_d    = 1'b0;
            end
            COUNT: begin
                if (done) begin
                    cet_n_d     = 1'b1;
                    mode_d      = M_HOLD;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = steps;
                    rsp_tc_d    = tc_q | tc_hit;
                end else begin
                    cnt_d = steps;
                    tc_d  = tc_q | tc_hit;
                end
            end
            OE_WAIT: begin
                if (gap_q >= TURN) begin
                    oe_n_d  = 1'b0;
                    rd_d    = 3'd0;
                    state_d = READ;
                end
            end
            READ: begin
                if (rd_q == RD_LAST) begin
                    oe_n_d      = 1'b1;
                    gap_d       = 3'd0;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bus_i;
                    rsp_tc_d    = 1'b0;
                end else begin
                    rd_d = rd_q + 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    rdy_d       = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cp_i or negedge mr_n_i) begin
        if (!mr_n_i) begin
            state_q     <= IDLE;
            mode_q      <= M_HOLD;
            oe_n_q      <= 1'b1;
            cet_n_q     <= 1'b1;
            bus_oe_q    <= 1'b0;
            bus_q       <= 8'd0;
            rdy_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
            rsp_tc_q    <= 1'b0;
            tc_q        <= 1'b0;
            cnt_q       <= 8'd0;
            n_q         <= 8'd0;
            data_q      <= 8'd0;
            rd_q        <= 3'd0;
            gap_q       <= TURN;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            oe_n_q      <= oe_n_d;
            cet_n_q     <= cet_n_d;
            bus_oe_q    <= bus_oe_d;
            bus_q       <= bus_d;
            rdy_q       <= rdy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tc_q    <= rsp_tc_d;
            tc_q        <= tc_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            data_q      <= data_d;
            rd_q        <= rd_d;
            gap_q       <= gap_d;
        end
    end

    assign cmd_ready_o = rdy_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_tc_o    = rsp_tc_q;
    assign s0_o        = mode_q[0];
    assign s1_o        = mode_q[1];
    assign oe_n_o      = oe_n_q;
    assign cet_n_o     = cet_n_q;
    assign bus_o       = bus_q;
    assign bus_oe_o    = bus_oe_q;

endmodule

// File: tb/tb_f779_seq.sv
// Scoreboard bench for f779_seq driving a behavioural 74F779 model.
// Responses are queued at issue and checked by an independent monitor.
module tb_f779_seq;

    localparam int T = 1;

    logic       cp_i = 1'b0;
    logic       mr_n_i = 1'b0;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic [1:0] cmd_op_i = 2'b00;
    logic [7:0] cmd_data_i = 8'd0;
    logic       rsp_valid_o;
    logic       rsp_ready_i = 1'b1;
    logic [7:0] rsp_data_o;
    logic       rsp_tc_o;
    logic       s0_o, s1_o, oe_n_o, cet_n_o;
    logic       tc_n_i;
    logic [7:0] bus_o;
    logic       bus_oe_o;
    logic [7:0] bus_i;

    f779_seq #(.TURN_CYCLES(T)) dut (
        .cp_i(cp_i), .mr_n_i(mr_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_data_i(cmd_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_tc_o(rsp_tc_o),
        .s0_o(s0_o), .s1_o(s1_o), .oe_n_o(oe_n_o), .cet_n_o(cet_n_o),
        .tc_n_i(tc_n_i), .bus_o(bus_o), .bus_oe_o(bus_oe_o), .bus_i(bus_i)
    );

    always #5 cp_i = ~cp_i;

    // 74F779 model: {S1,S0} 00 load, 01 down, 10 up, 11 hold
    logic [7:0] dev_q = 8'h00;
    logic [1:0] mode;
    assign mode = {s1_o, s0_o};
    assign bus_i = !oe_n_o ? dev_q : (bus_oe_o ? bus_o : 8'h00);
    assign tc_n_i = !(!cet_n_o && ((mode == 2'b10 && dev_q == 8'hFF) ||
                                   (mode == 2'b01 && dev_q == 8'h00)));
    always @(posedge cp_i) begin
        case (mode)
            2'b00: dev_q <= bus_i;
            2'b01: if (!cet_n_o) dev_q <= dev_q - 8'd1;
            2'b10: if (!cet_n_o) dev_q <= dev_q + 8'd1;
            default: dev_q <= dev_q;
        endcase
    end

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];
    bit mon_en = 0;
    int idle_cnt = 7;
    logic prev_oe_n = 1'b1;
    logic prev_bus_oe = 1'b0;
    bit cet_low_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // response monitor
    always @(negedge cp_i) begin
        if (mon_en && rsp_valid_o && rsp_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got data=%0h tc=%0b expected none",
                         rsp_data_o, rsp_tc_o);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({rsp_tc_o, rsp_data_o} !== e) begin
                    errors++;
                    $display("FAIL rsp: got tc=%0b data=%0h expected tc=%0b data=%0h",
                             rsp_tc_o, rsp_data_o, e[8], e[7:0]);
                end
            end
        end
    end

    // bus turnaround invariant
    always @(negedge cp_i) begin
        if (!mr_n_i) begin
            idle_cnt = 7;
        end else if (mon_en) begin
            if (!cet_n_o) cet_low_seen = 1;
            checks++;
            if (bus_oe_o && !oe_n_o) begin
                errors++;
                $display("FAIL bus_clash: bus_oe=1 oe_n=0 expected never both");
            end
            if (bus_oe_o && !prev_bus_oe) begin
                checks++;
                if (idle_cnt < T) begin
                    errors++;
                    $display("FAIL turn_bus_oe: got gap %0d expected >= %0d", idle_cnt, T);
                end
            end
            if (!oe_n_o && prev_oe_n) begin
                checks++;
                if (idle_cnt < T) begin
                    errors++;
                    $display("FAIL turn_oe: got gap %0d expected >= %0d", idle_cnt, T);
                end
            end
            idle_cnt = (oe_n_o && !bus_oe_o) ? ((idle_cnt < 7) ? idle_cnt + 1 : 7) : 0;
        end
        prev_oe_n = oe_n_o;
        prev_bus_oe = bus_oe_o;
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] d,
                         input bit has_rsp, input logic [7:0] ed, input logic et);
        int k;
        if (has_rsp) exp_q.push_back({et, ed});
        @(posedge cp_i); #1;
        cmd_valid_i = 1'b1;
        cmd_op_i = op;
        cmd_data_i = d;
        k = 0;
        do begin
            @(negedge cp_i);
            k++;
        end while (!cmd_ready_o && k < 300);
        chk("cmd_accept", cmd_ready_o, 1'b1);
        @(posedge cp_i); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 600) begin
            @(negedge cp_i);
            k++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge cp_i);
        chk("rst_s", {s1_o, s0_o}, 2'b11);
        chk("rst_oe_n", oe_n_o, 1'b1);
        chk("rst_cet_n", cet_n_o, 1'b1);
        chk("rst_bus_oe", bus_oe_o, 1'b0);
        chk("rst_bus_o", bus_o, 8'h00);
        chk("rst_cmd_ready", cmd_ready_o, 1'b0);
        chk("rst_rsp_valid", rsp_valid_o, 1'b0);
        chk("rst_rsp_data", rsp_data_o, 8'h00);
        chk("rst_rsp_tc", rsp_tc_o, 1'b0);
        @(posedge cp_i); #1;
        mr_n_i = 1'b1;
        mon_en = 1;
        @(posedge cp_i);
        @(negedge cp_i);
        chk("ready_after_rst", cmd_ready_o, 1'b1);

        // load then read back
        issue(2'b00, 8'hA5, 1, 8'h00, 1'b0);
        issue(2'b11, 8'h00, 1, 8'hA5, 1'b0);
        drain();

        // count up across FF->00
        issue(2'b00, 8'hFD, 1, 8'h00, 1'b0);
        issue(2'b01, 8'd3, 1, 8'd3, 1'b1);
        issue(2'b11, 8'h00, 1, 8'h00, 1'b0);
        drain();

        // count down, no terminal count
        issue(2'b00, 8'h05, 1, 8'h00, 1'b0);
        issue(2'b10, 8'd2, 1, 8'd2, 1'b0);
        issue(2'b11, 8'h00, 1, 8'h03, 1'b0);
        drain();

        // N=0 is a no-op
        cet_low_seen = 0;
        issue(2'b01, 8'd0, 1, 8'd0, 1'b0);
        drain();
        chk("n0_cet_quiet", cet_low_seen, 1'b0);
        issue(2'b11, 8'h00, 1, 8'h03, 1'b0);
        drain();

        // terminal count in the middle of a count
        issue(2'b00, 8'hFE, 1, 8'h00, 1'b0);
`ifdef F779_SEQ_STOP_ON_TC_EN
        issue(2'b01, 8'd5, 1, 8'd2, 1'b1);
        issue(2'b11, 8'h00, 1, 8'h00, 1'b0);
`else
        issue(2'b01, 8'd5, 1, 8'd5, 1'b1);
        issue(2'b11, 8'h00, 1, 8'h03, 1'b0);
`endif
        drain();

        // response back-pressure
        issue(2'b00, 8'h3C, 1, 8'h00, 1'b0);
        drain();
        rsp_ready_i = 1'b0;
        issue(2'b11, 8'h00, 1, 8'h3C, 1'b0);
        begin
            int k;
            k = 0;
            while (!rsp_valid_o && k < 50) begin
                @(negedge cp_i);
                k++;
            end
        end
        chk("stall_rsp_seen", rsp_valid_o, 1'b1);
        @(posedge cp_i); #1;
        cmd_valid_i = 1'b1;
        cmd_op_i = 2'b00;
        cmd_data_i = 8'h77;
        for (int i = 0; i < 10; i++) begin
            @(negedge cp_i);
            chk("stall_valid", rsp_valid_o, 1'b1);
            chk("stall_data", rsp_data_o, 8'h3C);
            chk("stall_ready", cmd_ready_o, 1'b0);
        end
        @(posedge cp_i); #1;
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        drain();
        issue(2'b11, 8'h00, 1, 8'h3C, 1'b0);
        drain();

        // reset during a long count
        issue(2'b01, 8'd200, 0, 8'h00, 1'b0);
        repeat (5) @(negedge cp_i);
        chk("midcnt_cet", cet_n_o, 1'b0);
        @(posedge cp_i); #1;
        mr_n_i = 1'b0;
        @(negedge cp_i);
        chk("midrst_cet", cet_n_o, 1'b1);
        chk("midrst_s", {s1_o, s0_o}, 2'b11);
        chk("midrst_rsp", rsp_valid_o, 1'b0);
        @(posedge cp_i); #1;
        mr_n_i = 1'b1;
        repeat (220) @(negedge cp_i);
        chk("midrst_no_rsp", rsp_valid_o, 1'b0);
        issue(2'b00, 8'h5A, 1, 8'h00, 1'b0);
        issue(2'b11, 8'h00, 1, 8'h5A, 1'b0);
        drain();

        repeat (5) @(negedge cp_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
